rand_arbiter: RTL
=================

# rand_arbiter

Shares one 32-bit maximal-length LFSR between up to NUM_REQ game-logic requesters, such as spawners, enemy AI and item drops. Each requester asks for a uniformly distributed value in [0, bound). The block arbitrates round-robin, reduces range by masked rejection sampling with a bounded retry count, and returns the value with a one-cycle acknowledge. It sits between the free-running random source and the game state machines in the 25 MHz pixel-clock domain.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- OUT_W, 10, width of bound and returned value
- MAX_TRIES, 8, rejection draws before the deterministic fallback (≥1)
- SEED, 32'hACE1ACE1, LFSR value after reset and on zero-seed load

Ports:
- clk  in  1  single clock; all state changes on posedge
- rst_n  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-requester request level
- bound  in  NUM_REQ*OUT_W  packed, requester i at [i*OUT_W +: OUT_W]; 0 = full range
- seed_load  in  1  load seed_in into the LFSR
- seed_in  in  32  new seed value
- ack  out  NUM_REQ  one-hot, one-cycle pulse; the value is for requester i
- rand_data  out  OUT_W  result, valid only while any ack bit is high
- gnt_id  out  $clog2(NUM_REQ)  index of the requester being served
- busy  out  1  high in DRAW and DONE

## Operation
- LFSR: taps 32,22,2,1, shift-left with feedback into bit 0. It steps every cycle unconditionally; sample = lfsr[OUT_W-1:0].
- FSM has three states, with IDLE after reset.
  - IDLE: if req is nonzero, the arbiter grants the first set bit at or after rr_ptr, wrapping. It latches gnt_id, bound and mask, clears try_cnt, and moves to DRAW. It stays in IDLE otherwise.
  - DRAW: m = sample & mask.
    - bound==0 → accept sample.
    - m < bound → accept m.
    - Otherwise increment try_cnt. If try_cnt reaches MAX_TRIES, accept m − bound; this is guaranteed < bound because mask < 2·bound.
    - On accept, register rand_data and ack[gnt_id], then go to DONE.
    - If req[gnt_id] drops while in DRAW, abort to IDLE with no ack.
  - DONE: ack is high for this single cycle. rr_ptr ← gnt_id+1 mod NUM_REQ. Next state is IDLE.
- mask = (smallest power of two ≥ bound) − 1. bound=1 gives mask=0, so the result is 0.
- seed_load: takes effect in any state, loading next cycle. seed_in==0 loads SEED instead. A draw in the same cycle uses the old LFSR value.
- A requester must deassert req in the ack cycle or the cycle after. If req is still high in IDLE, it is treated as a new request.

## Timing
- Reset (rst_n low at posedge) sets: ack=0, rand_data=0, gnt_id=0, busy=0, rr_ptr=0, state IDLE, lfsr=SEED. Reset overrides seed_load and any in-flight draw.
- Latency: a request seen in IDLE at cycle t gives ack at t+1+k, where k is the number of draws (1..MAX_TRIES). Minimum is 2 cycles; maximum is MAX_TRIES+1.
- Throughput: at least 3 cycles per transaction (IDLE, DRAW, DONE). No request is ever starved; worst-case wait is NUM_REQ transactions.
- Requests that arrive during busy are held by the requester and served later. The block does not queue them.
- rand_data holds its last value after ack falls.

## Structure
- Package rand_pkg:
  - state enum {IDLE, DRAW, DONE}
  - LFSR tap constants
  - default SEED
  - mask-from-bound function
- Sub-module lfsr32_core (clk, rst_n, load, load_val, q): stepping and zero-seed substitution.
- Top level holds the arbiter, FSM, try counter and result register.

## Test plan
- Reset, then req=0001 and bound[0]=1 → ack=0001 exactly 2 cycles after the request is sampled; rand_data=0; busy high for 2 cycles.
- bound[0]=0 (full range) → rand_data equals lfsr[9:0] in the DRAW cycle, checked against a 32-bit reference model from SEED 0xACE1ACE1.
- req=1111 held and each bound=16 → ack order 0001, 0010, 0100, 1000, 0001. Every rand_data is < 16 and gnt_id tracks the same order.
- MAX_TRIES=1, bound=513: any sample ≥ 513 → rand_data = sample − 513; ack is always at t+2.
- seed_load with seed_in=0 → lfsr equals 0xACE1ACE1 next cycle. seed_in=0x12345678 → model resyncs and later draws match.
- rst_n low during DRAW → no ack; state IDLE, lfsr=SEED and rr_ptr=0 the next cycle. Dropping req mid-DRAW → abort with no ack.

Source files
------------

// File: rtl/rand_pkg.sv
// Shared types and constants for the random-number arbiter: FSM states,
// LFSR tap mask, default seed and the bound-to-mask helper.
package rand_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_e;

    // Taps 32,22,2,1 expressed as zero-based bit positions 31,21,1,0.
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_ACE1;

    // Smallest power of two >= b, minus one; b==0 yields all ones (full range).
    function automatic logic [31:0] mask_from_bound(input logic [31:0] b);
        logic [31:0] v;
        v = b - 32'd1;
        v = v | (v >> 1);
        v = v | (v >> 2);
        v = v | (v >> 4);
        v = v | (v >> 8);
        v = v | (v >> 16);
        return v;
    endfunction

endpackage

// File: rtl/lfsr32_core.sv
// Free-running 32-bit maximal-length LFSR with seed load; a zero seed is
// replaced by SEED so the register can never lock up in the all-zero state.
module lfsr32_core
    import rand_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] q
);

    logic [31:0] q_q;
    logic [31:0] q_d;

    // Next value: load (with zero-seed substitution) or one left shift step.
    always_comb begin
        q_d = {q_q[30:0], ^(q_q & LFSR_TAPS)};
        if (load) begin
            q_d = (load_val == 32'd0) ? SEED : load_val;
        end else begin
            q_d = {q_q[30:0], ^(q_q & LFSR_TAPS)};
        end
    end

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter handing out bounded random values from one shared LFSR,
// using masked rejection sampling with a deterministic fallback after MAX_TRIES.
module rand_arbiter
    import rand_pkg::*;
#(
    parameter int          NUM_REQ   = 4,
    parameter int          OUT_W     = 10,
    parameter int          MAX_TRIES = 8,
    parameter logic [31:0] SEED      = DEFAULT_SEED
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*OUT_W-1:0]   bound,
    input  logic                       seed_load,
    input  logic [31:0]                seed_in,
    output logic [NUM_REQ-1:0]         ack,
    output logic [OUT_W-1:0]           rand_data,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int IDX_W = ID_W + 1;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    logic [31:0]        lfsr_s;
    logic [31:0]        mask_full_s;
    logic               lfsr_unused_s;
    logic [OUT_W-1:0]   sample_s, m_s, bound_sel_s;
    logic [TRY_W-1:0]   try_inc_s;
    logic               pick_vld_s;
    logic [ID_W-1:0]    pick_id_s;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d, rr_ptr_q, rr_ptr_d;
    logic [OUT_W-1:0]   bound_q, bound_d, mask_q, mask_d, rand_data_q, rand_data_d;
    logic [TRY_W-1:0]   try_cnt_q, try_cnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               busy_q, busy_d;

    lfsr32_core #(.SEED(SEED)) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (seed_load),
        .load_val (seed_in),
        .q        (lfsr_s)
    );

    assign sample_s      = lfsr_s[OUT_W-1:0];
    assign m_s           = sample_s & mask_q;
    assign try_inc_s     = try_cnt_q + TRY_W'(1);
    assign bound_sel_s   = bound[pick_id_s*OUT_W +: OUT_W];
    assign mask_full_s   = mask_from_bound(32'(bound_sel_s));
    assign lfsr_unused_s = ^{lfsr_s, mask_full_s};

    // Round-robin pick: scan from the highest offset down so the requester
    // nearest to rr_ptr (wrapping) is the one left standing.
    always_comb begin : rr_pick
        logic [IDX_W-1:0] sum;
        logic [ID_W-1:0]  idx;
        pick_vld_s = 1'b0;
        pick_id_s  = '0;
        sum        = '0;
        idx        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum        = {1'b0, rr_ptr_q} + IDX_W'(i);
            idx        = (sum >= IDX_W'(NUM_REQ)) ? ID_W'(sum - IDX_W'(NUM_REQ)) : ID_W'(sum);
            pick_vld_s = pick_vld_s | req[idx];
            pick_id_s  = req[idx] ? idx : pick_id_s;
        end
    end

    // FSM next-state, draw acceptance and result capture.
    always_comb begin
        state_d     = state_q;
        gnt_id_d    = gnt_id_q;
        rr_ptr_d    = rr_ptr_q;
        bound_d     = bound_q;
        mask_d      = mask_q;
        try_cnt_d   = try_cnt_q;
        rand_data_d = rand_data_q;
        ack_d       = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld_s) begin
                    state_d   = DRAW;
                    gnt_id_d  = pick_id_s;
                    bound_d   = bound_sel_s;
                    mask_d    = mask_full_s[OUT_W-1:0];
                    try_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAW: begin
                // A dropped request wins over a draw that would otherwise accept.
                if (!req[gnt_id_q]) begin
                    state_d = IDLE;
                end else if (bound_q == '0) begin
                    rand_data_d     = sample_s;
                    ack_d[gnt_id_q] = 1'b1;
                    state_d         = DONE;
                end else if (m_s < bound_q) begin
                    rand_data_d     = m_s;
                    ack_d[gnt_id_q] = 1'b1;
                    state_d         = DONE;
                end else if (try_inc_s == TRY_W'(MAX_TRIES)) begin
                    rand_data_d     = m_s - bound_q;
                    ack_d[gnt_id_q] = 1'b1;
                    state_d         = DONE;
                end else begin
                    try_cnt_d = try_inc_s;
                end
            end
            DONE: begin
                rr_ptr_d = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_id_q    <= '0;
            rr_ptr_q    <= '0;
            bound_q     <= '0;
            mask_q      <= '0;
            try_cnt_q   <= '0;
            rand_data_q <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_id_q    <= gnt_id_d;
            rr_ptr_q    <= rr_ptr_d;
            bound_q     <= bound_d;
            mask_q      <= mask_d;
            try_cnt_q   <= try_cnt_d;
            rand_data_q <= rand_data_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
        end
    end

    assign ack       = ack_q;
    assign rand_data = rand_data_q;
    assign gnt_id    = gnt_id_q;
    assign busy      = busy_q;

endmodule
